// File: rtl/reg_share_arb.sv
// reg_share_arb: round-robin arbiter that shares one DW-bit storage register
// among N_REQ requesters. Each grant loads the winner's data into q. After a
// grant, the resource stays occupied for HOLD cycles before the next grant.
//
// Optional build macro ARB_FIXED_PRIO_EN: when it is defined, the winner is
// the lowest-index requester. owner is still updated but is not used to pick
// the winner. When the macro is undefined, selection is round-robin from the
// requester after owner.
module reg_share_arb #(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int HOLD  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DW-1:0]      wdata,
  output logic [DW-1:0]            q,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] owner
);

  localparam int OW = $clog2(N_REQ);
  // The hold counter counts down from HOLD-2. It is kept at least 1 bit wide
  // so that short holds still build cleanly.
  localparam int CW = (HOLD > 2) ? $clog2(HOLD - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = (HOLD > 1) ? CW'(HOLD - 2) : '0;
  localparam logic [OW-1:0] OWNER_RST = OW'(N_REQ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                r_state, w_stateNext;
  logic [CW-1:0]         r_cnt, w_cntNext;
  logic [DW-1:0]         r_q, w_qNext;
  logic [N_REQ-1:0]      r_gnt, w_gntNext;
  logic [OW-1:0]         r_owner, w_ownerNext;
  logic [OW-1:0]         w_winner;
  logic [DW-1:0]         w_winData;

`ifdef ARB_FIXED_PRIO_EN
  // Pick the lowest-index active request. The descending loop lets the lowest index overwrite any higher one.
  always_comb begin : pickWinner
    w_winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) w_winner = OW'(i);
    end
  end
`else
  // Search from owner+1 onward, wrapping around. The descending loop lets the closest active request win.
  always_comb begin : pickWinner
    logic [OW:0] idx;
    w_winner = '0;
    idx      = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = {1'b0, r_owner} + (OW + 1)'(i);
      if (idx >= (OW + 1)'(N_REQ)) idx = idx - (OW + 1)'(N_REQ);
      if (req[idx[OW-1:0]]) w_winner = idx[OW-1:0];
    end
  end
`endif

  // Select only the winner's lane, so unknown data on the other lanes cannot reach q.
  always_comb begin
    w_winData = wdata[int'(w_winner) * DW +: DW];
  end

  // Next-state logic: grant in IDLE when any request is active, then count down the hold in BUSY.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_qNext     = r_q;
    w_gntNext   = '0;
    w_ownerNext = r_owner;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_qNext             = w_winData;
          w_gntNext[w_winner] = 1'b1;
          w_ownerNext         = w_winner;
          if (HOLD > 1) begin
            w_cntNext   = CNT_INIT;
            w_stateNext = BUSY;
          end
        end
      end
      BUSY: begin
        if (r_cnt == '0) w_stateNext = IDLE;
        else             w_cntNext   = r_cnt - CW'(1);
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // State and output registers. Reset is asynchronous and gives requester 0 first turn afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_gnt   <= '0;
      r_owner <= OWNER_RST;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_q     <= w_qNext;
      r_gnt   <= w_gntNext;
      r_owner <= w_ownerNext;
    end
  end

  assign q     = r_q;
  assign gnt   = r_gnt;
  assign owner = r_owner;
  assign busy  = (r_state == BUSY);

endmodule

// File: tb/tb_reg_share_arb.sv
// tb_reg_share_arb: directed bench for reg_share_arb. It instantiates three
// copies of the design with HOLD=2, HOLD=4 and HOLD=1. Expected grants are
// queued per instance, and a negedge monitor pops and compares them
// whenever a grant appears.
module tb_reg_share_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req2, req4, req1;
  logic [31:0] wdata;

  logic [7:0]  q2, q4, q1;
  logic [3:0]  gnt2, gnt4, gnt1;
  logic        busy2, busy4, busy1;
  logic [1:0]  own2, own4, own1;

  typedef struct packed {
    logic [3:0] gnt;
    logic [7:0] q;
    logic [1:0] owner;
  } exp_t;

  exp_t expQ[3][$];
  int   holdOf[3]  = '{2, 4, 1};
  int   lastGnt[3] = '{-1, -1, -1};
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  reg_share_arb #(.N_REQ(4), .DW(8), .HOLD(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .wdata(wdata),
    .q(q2), .gnt(gnt2), .busy(busy2), .owner(own2));

  reg_share_arb #(.N_REQ(4), .DW(8), .HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .wdata(wdata),
    .q(q4), .gnt(gnt4), .busy(busy4), .owner(own4));

  reg_share_arb #(.N_REQ(4), .DW(8), .HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .wdata(wdata),
    .q(q1), .gnt(gnt1), .busy(busy1), .owner(own1));

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
               name, actual, required, cyc);
    end
  endtask

  task automatic applyStimulus(input int d, input logic [3:0] r);
    case (d)
      0:       req2 = r;
      1:       req4 = r;
      default: req1 = r;
    endcase
  endtask

  task automatic pushExp(input int d, input logic [3:0] g, input logic [7:0] qv,
                         input logic [1:0] o);
    exp_t e;
    e.gnt   = g;
    e.q     = qv;
    e.owner = o;
    expQ[d].push_back(e);
  endtask

  task automatic monitorStep(input int d, input logic [3:0] g, input logic [7:0] qv,
                             input logic [1:0] o);
    exp_t e;
    if (!rst_n) begin
      lastGnt[d] = -1;
    end else if (g != 4'b0000) begin
      if (expQ[d].size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_gnt[%0d]: got gnt=%b, expected no grant at cycle %0d",
                 d, g, cyc);
      end else begin
        e = expQ[d].pop_front();
        checkOutput($sformatf("gnt[%0d]", d), 32'(g), 32'(e.gnt));
        checkOutput($sformatf("q[%0d]", d), 32'(qv), 32'(e.q));
        checkOutput($sformatf("owner[%0d]", d), 32'(o), 32'(e.owner));
      end
      if (lastGnt[d] >= 0) begin
        checks++;
        if (cyc - lastGnt[d] < holdOf[d]) begin
          errors++;
          $display("[TB] FAIL spacing[%0d]: got gap %0d, expected at least %0d",
                   d, cyc - lastGnt[d], holdOf[d]);
        end
      end
      lastGnt[d] = cyc;
    end
  endtask

  // Monitor: on each falling edge, compare every new grant against its queue.
  always @(negedge clk) begin
    cyc++;
    monitorStep(0, gnt2, q2, own2);
    monitorStep(1, gnt4, q4, own4);
    monitorStep(2, gnt1, q1, own1);
  end

  // Wait until the monitor has consumed every queued grant for instance d. A limit bounds the wait.
  task automatic waitDrain(input int d, input int limit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      #1;
      if (expQ[d].size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout[%0d]: got %0d pending, expected 0",
               d, expQ[d].size());
    end
  endtask

  initial begin
    rst_n = 1'b1;
    req2  = '0;
    req4  = '0;
    req1  = '0;
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};

    // Reset is asserted before the first clock edge and must act immediately.
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_q", 32'(q2), 32'h00);
    checkOutput("rst_gnt", 32'(gnt2), 32'h0);
    checkOutput("rst_busy", 32'(busy2), 32'h0);
    checkOutput("rst_owner", 32'(own2), 32'h3);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Single request with unknown data on the other lanes.
    wdata = {8'hxx, 8'hA5, 8'hxx, 8'hxx};
    applyStimulus(0, 4'b0100);
    pushExp(0, 4'b0100, 8'hA5, 2'd2);
    waitDrain(0, 5);
    checkOutput("single_busy_on", 32'(busy2), 32'h1);
    applyStimulus(0, 4'b0000);
    @(negedge clk);
    #1;
    checkOutput("single_gnt_off", 32'(gnt2), 32'h0);
    checkOutput("single_busy_off", 32'(busy2), 32'h0);
    checkOutput("single_q_held", 32'(q2), 32'hA5);

    // Full request with owner=2. After this grant, reset is asserted between edges.
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    applyStimulus(0, 4'b1111);
`ifdef ARB_FIXED_PRIO_EN
    pushExp(0, 4'b0001, 8'h11, 2'd0);
`else
    pushExp(0, 4'b1000, 8'h44, 2'd3);
`endif
    waitDrain(0, 5);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_q", 32'(q2), 32'h00);
    checkOutput("async_gnt", 32'(gnt2), 32'h0);
    checkOutput("async_busy", 32'(busy2), 32'h0);
    checkOutput("async_owner", 32'(own2), 32'h3);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Full contention starting from the reset pointer, with all requests held.
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++) pushExp(0, 4'b0001, 8'h11, 2'd0);
`else
    pushExp(0, 4'b0001, 8'h11, 2'd0);
    pushExp(0, 4'b0010, 8'h22, 2'd1);
    pushExp(0, 4'b0100, 8'h33, 2'd2);
    pushExp(0, 4'b1000, 8'h44, 2'd3);
    pushExp(0, 4'b0001, 8'h11, 2'd0);
`endif
    waitDrain(0, 20);
    applyStimulus(0, 4'b0000);

    // Pointer wrap from owner=0 with requesters 3 and 0 active.
    @(negedge clk);
    #1;
    applyStimulus(0, 4'b1001);
`ifdef ARB_FIXED_PRIO_EN
    pushExp(0, 4'b0001, 8'h11, 2'd0);
    pushExp(0, 4'b0001, 8'h11, 2'd0);
`else
    pushExp(0, 4'b1000, 8'h44, 2'd3);
    pushExp(0, 4'b0001, 8'h11, 2'd0);
`endif
    waitDrain(0, 10);
    applyStimulus(0, 4'b0000);

    // HOLD=4: grant requester 0, then reset while busy. After reset, requester 0 must win again.
    @(negedge clk);
    #1;
    applyStimulus(1, 4'b0001);
    pushExp(1, 4'b0001, 8'h11, 2'd0);
    waitDrain(1, 5);
    checkOutput("h4_busy_before_rst", 32'(busy4), 32'h1);
    applyStimulus(1, 4'b0000);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("h4_busy_in_rst", 32'(busy4), 32'h0);
    checkOutput("h4_owner_in_rst", 32'(own4), 32'h3);
    @(negedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1, 4'b0011);
    pushExp(1, 4'b0001, 8'h11, 2'd0);
    waitDrain(1, 5);
    applyStimulus(1, 4'b0000);
    checkOutput("h4_busy_c1", 32'(busy4), 32'h1);
    @(negedge clk);
    #1 checkOutput("h4_busy_c2", 32'(busy4), 32'h1);
    @(negedge clk);
    #1 checkOutput("h4_busy_c3", 32'(busy4), 32'h1);
    @(negedge clk);
    #1 checkOutput("h4_busy_c4", 32'(busy4), 32'h0);

    // HOLD=1: with requests held, a grant is expected every cycle and busy stays low.
    applyStimulus(2, 4'b0011);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) pushExp(2, 4'b0001, 8'h11, 2'd0);
`else
    pushExp(2, 4'b0001, 8'h11, 2'd0);
    pushExp(2, 4'b0010, 8'h22, 2'd1);
    pushExp(2, 4'b0001, 8'h11, 2'd0);
    pushExp(2, 4'b0010, 8'h22, 2'd1);
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 checkOutput("h1_busy", 32'(busy1), 32'h0);
    end
    checkOutput("h1_pending", 32'(expQ[2].size()), 32'h0);
    applyStimulus(2, 4'b0000);

    // Idle for a few cycles so that any stray grant is flagged by the monitor.
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++)
      checkOutput($sformatf("final_pending[%0d]", d), 32'(expQ[d].size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
